// File: rtl/lzd_share_arbiter.sv
// Round-robin shared leading-one detector: grants one requester at a time, encodes the
// captured operand's msb and normalisation shift, and holds the tagged result until accepted.
module lzd_share_arbiter #(
    parameter int unsigned NUM_REQ   = 4,
    parameter int unsigned TAG_W     = 2,
    parameter int unsigned WIDTH     = 106,
    parameter int unsigned WIDTH_LOG = 7
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [NUM_REQ*WIDTH-1:0]   req_data,
    output logic [NUM_REQ-1:0]         req_ready,
    output logic                       rsp_valid,
    input  logic                       rsp_ready,
    output logic [TAG_W-1:0]           rsp_id,
    output logic [WIDTH_LOG-1:0]       rsp_msb,
    output logic [WIDTH_LOG-1:0]       rsp_shift,
    output logic                       rsp_zero,
    output logic                       busy
);

    localparam int unsigned PadW = 1 << WIDTH_LOG;

    typedef enum logic [1:0] {StIdle, StEncode, StHold} state_e;

    state_e               state_q;
    logic [TAG_W-1:0]     last_grant_q;
    logic [TAG_W-1:0]     tag_q;
    logic [WIDTH-1:0]     op_q;
    logic                 rsp_valid_q;
    logic [TAG_W-1:0]     rsp_id_q;
    logic [WIDTH_LOG-1:0] rsp_msb_q;
    logic [WIDTH_LOG-1:0] rsp_shift_q;
    logic                 rsp_zero_q;

    logic                 found;
    logic [TAG_W-1:0]     winner;
    logic [PadW-1:0]      win;
    logic [WIDTH_LOG-1:0] msb;
    logic [WIDTH_LOG-1:0] shift;
    logic                 op_zero;

    // Scan from the farthest offset down so the nearest valid requester after last_grant wins.
    always_comb begin
        int unsigned idx;
        found  = 1'b0;
        winner = '0;
        idx    = 0;
        for (int unsigned i = NUM_REQ; i >= 1; i--) begin
            idx = (int'(last_grant_q) + i) % NUM_REQ;
            if (req_valid[idx]) begin
                found  = 1'b1;
                winner = TAG_W'(idx);
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (state_q == StIdle && found) begin
            req_ready[winner] = 1'b1;
        end
    end

    // Binary search: bits above the current window are always zero, so testing the
    // shifted-down value is enough to ask whether the upper half holds a one.
    always_comb begin
        win = PadW'(op_q);
        msb = '0;
        for (int l = int'(WIDTH_LOG) - 1; l >= 0; l--) begin
            if (|(win >> (1 << l))) begin
                msb[l] = 1'b1;
                win    = win >> (1 << l);
            end
        end
        op_zero = ~|op_q;
        shift   = op_zero ? WIDTH_LOG'(WIDTH) : WIDTH_LOG'(WIDTH - 1) - msb;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            last_grant_q <= TAG_W'(NUM_REQ - 1);
            tag_q        <= '0;
            op_q         <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_id_q     <= '0;
            rsp_msb_q    <= '0;
            rsp_shift_q  <= '0;
            rsp_zero_q   <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (found) begin
                        op_q         <= req_data[winner*WIDTH +: WIDTH];
                        tag_q        <= winner;
                        last_grant_q <= winner;
                        state_q      <= StEncode;
                    end
                end
                StEncode: begin
                    rsp_msb_q   <= msb;
                    rsp_shift_q <= shift;
                    rsp_zero_q  <= op_zero;
                    rsp_id_q    <= tag_q;
                    rsp_valid_q <= 1'b1;
                    state_q     <= StHold;
                end
                StHold: begin
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        state_q     <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_msb   = rsp_msb_q;
    assign rsp_shift = rsp_shift_q;
    assign rsp_zero  = rsp_zero_q;
    assign busy      = (state_q != StIdle);

endmodule

// File: tb/tb_lzd_share_arbiter.sv
// Scoreboard bench for lzd_share_arbiter: a cycle model predicts grants and handshakes,
// expected results are queued at accept and compared while the DUT holds its response.
module tb_lzd_share_arbiter;

    localparam int NUM_REQ   = 4;
    localparam int TAG_W     = 2;
    localparam int WIDTH     = 106;
    localparam int WIDTH_LOG = 7;

    logic                     clk;
    logic                     rst;
    logic [NUM_REQ-1:0]       req_valid;
    logic [NUM_REQ*WIDTH-1:0] req_data;
    logic [NUM_REQ-1:0]       req_ready;
    logic                     rsp_valid;
    logic                     rsp_ready;
    logic [TAG_W-1:0]         rsp_id;
    logic [WIDTH_LOG-1:0]     rsp_msb;
    logic [WIDTH_LOG-1:0]     rsp_shift;
    logic                     rsp_zero;
    logic                     busy;

    lzd_share_arbiter #(
        .NUM_REQ   (NUM_REQ),
        .TAG_W     (TAG_W),
        .WIDTH     (WIDTH),
        .WIDTH_LOG (WIDTH_LOG)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_msb   (rsp_msb),
        .rsp_shift (rsp_shift),
        .rsp_zero  (rsp_zero),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0] id;
        logic [6:0] msb;
        logic [6:0] shift;
        logic       zero;
    } rsp_t;

    int         n_checks = 0;
    int         n_pass   = 0;
    rsp_t       exp_q[$];
    rsp_t       m_rsp;
    rsp_t       seen_rsp;
    int         m_state  = 0;
    logic [1:0] m_ptr    = 2'd3;
    int         grant_log[$];
    int         grant_cyc[$];
    int         cyc      = 0;
    bit         armed    = 1'b0;
    logic [3:0] sticky   = 4'h0;

    task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    endtask

    function automatic rsp_t ref_rsp(input int id, input logic [WIDTH-1:0] d);
        rsp_t r;
        r.id   = 2'(id);
        r.msb  = '0;
        r.zero = 1'b1;
        for (int i = 0; i < WIDTH; i++) begin
            if (d[i]) begin
                r.msb  = 7'(i);
                r.zero = 1'b0;
            end
        end
        r.shift = r.zero ? 7'(WIDTH) : 7'(WIDTH - 1 - int'(r.msb));
        return r;
    endfunction

    function automatic int rr_pick(input logic [1:0] ptr, input logic [3:0] v);
        for (int off = 1; off <= NUM_REQ; off++) begin
            int k;
            k = (int'(ptr) + off) % NUM_REQ;
            if (v[k]) return k;
        end
        return -1;
    endfunction

    // Cycle model and scoreboard, sampled mid-cycle while inputs are stable.
    always @(negedge clk) begin : mon
        int         w;
        logic [3:0] exp_rdy;
        cyc++;
        w = rr_pick(m_ptr, req_valid);
        if (armed) begin
            exp_rdy = 4'h0;
            if (m_state == 0 && w >= 0) exp_rdy[w] = 1'b1;
            check_val("req_ready", 128'(req_ready), 128'(exp_rdy));
            check_val("rsp_valid", 128'(rsp_valid), 128'(m_state == 2));
            check_val("busy", 128'(busy), 128'(m_state != 0));
            check_val("rsp_id", 128'(rsp_id), 128'(m_rsp.id));
            check_val("rsp_msb", 128'(rsp_msb), 128'(m_rsp.msb));
            check_val("rsp_shift", 128'(rsp_shift), 128'(m_rsp.shift));
            check_val("rsp_zero", 128'(rsp_zero), 128'(m_rsp.zero));
        end
        if (rst) begin
            m_state = 0;
            m_ptr   = 2'd3;
            m_rsp   = '0;
            exp_q.delete();
            armed   = 1'b1;
        end else if (armed) begin
            case (m_state)
                0: if (w >= 0) begin
                    exp_q.push_back(ref_rsp(w, req_data[w*WIDTH +: WIDTH]));
                    grant_log.push_back(w);
                    grant_cyc.push_back(cyc);
                    m_ptr   = 2'(w);
                    m_state = 1;
                end
                1: begin
                    if (exp_q.size() == 0) check_val("sb_empty", 128'(0), 128'(1));
                    else m_rsp = exp_q.pop_front();
                    m_state = 2;
                end
                default: if (rsp_ready) begin
                    seen_rsp = '{id: rsp_id, msb: rsp_msb, shift: rsp_shift, zero: rsp_zero};
                    m_state  = 0;
                end
            endcase
        end
    end

    // Advance one cycle; drop the valid of any requester accepted at this edge.
    task automatic tick();
        logic [3:0] g;
        @(negedge clk);
        g = rst ? 4'h0 : (req_ready & req_valid);
        @(posedge clk);
        #1;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (g[k] && !sticky[k]) req_valid[k] = 1'b0;
        end
    endtask

    task automatic issue(input int k, input logic [WIDTH-1:0] d);
        req_data[k*WIDTH +: WIDTH] = d;
        req_valid[k] = 1'b1;
    endtask

    task automatic wait_done(input int maxc);
        int c = 0;
        while ((m_state != 0 || req_valid != 0) && c < maxc) begin
            tick();
            c++;
        end
        if (c >= maxc) check_val("done_timeout", 128'(0), 128'(1));
    endtask

    task automatic wait_hold(input int maxc);
        int c = 0;
        while (m_state != 2 && c < maxc) begin
            tick();
            c++;
        end
        if (m_state != 2) check_val("hold_timeout", 128'(0), 128'(1));
    endtask

    task automatic check_grant(input string tag, input int idx, input int exp);
        if (idx < grant_log.size()) check_val(tag, 128'(grant_log[idx]), 128'(exp));
        else check_val(tag, '1, 128'(exp));
    endtask

    logic [WIDTH-1:0] enc_data[5];
    int               enc_msb[5]   = '{105, 3, 0, 0, 105};
    int               enc_shift[5] = '{0, 102, 105, 106, 0};
    int               enc_zero[5]  = '{0, 0, 0, 1, 0};
    int               rr_order[6]  = '{0, 1, 2, 3, 0, 1};

    initial begin
        int start;
        int c;
        rst       = 1'b1;
        rsp_ready = 1'b1;
        req_valid = '0;
        req_data  = '0;
        enc_data[0] = '0;
        enc_data[0][105] = 1'b1;
        enc_data[1] = WIDTH'(8);
        enc_data[2] = WIDTH'(1);
        enc_data[3] = '0;
        enc_data[4] = '1;
        repeat (2) tick();
        rst = 1'b0;
        tick();

        // Directed encoder values: first on req0, the rest on req1.
        for (int i = 0; i < 5; i++) begin
            issue((i == 0) ? 0 : 1, enc_data[i]);
            wait_done(20);
            check_val("enc_id", 128'(seen_rsp.id), 128'((i == 0) ? 0 : 1));
            check_val("enc_msb", 128'(seen_rsp.msb), 128'(enc_msb[i]));
            check_val("enc_shift", 128'(seen_rsp.shift), 128'(enc_shift[i]));
            check_val("enc_zero", 128'(seen_rsp.zero), 128'(enc_zero[i]));
        end

        // Pointer wrap: after req3, req0 beats req2.
        issue(3, WIDTH'(64'h1234_5678));
        wait_done(20);
        start = grant_log.size();
        issue(0, WIDTH'(64'h0f00));
        issue(2, WIDTH'(64'h00f0));
        wait_done(40);
        check_grant("wrap_first", start, 0);
        check_grant("wrap_second", start + 1, 2);

        // All requesters held valid: strict rotation, one accept every 3 cycles.
        issue(3, WIDTH'(5));
        wait_done(20);
        for (int k = 0; k < NUM_REQ; k++) issue(k, WIDTH'(64'h1) << (k * 20 + 3));
        sticky = 4'hF;
        start  = grant_log.size();
        c      = 0;
        while (grant_log.size() - start < 6 && c < 60) begin
            tick();
            c++;
        end
        req_valid = '0;
        sticky    = 4'h0;
        wait_done(20);
        for (int i = 0; i < 6; i++) check_grant("rr_order", start + i, rr_order[i]);
        for (int i = 1; i < 6; i++) begin
            if (start + i < grant_cyc.size())
                check_val("rr_interval", 128'(grant_cyc[start+i] - grant_cyc[start+i-1]), 128'(3));
            else
                check_val("rr_interval", '1, 128'(3));
        end

        // Backpressure with req2 and req3 pending.
        rsp_ready = 1'b0;
        start     = grant_log.size();
        issue(2, WIDTH'(64'h8000_0000_0000));
        issue(3, WIDTH'(64'h3));
        wait_hold(10);
        repeat (5) tick();
        rsp_ready = 1'b1;
        wait_done(30);
        check_grant("bp_first", start, 2);
        check_grant("bp_second", start + 1, 3);

        // Reset while holding a result; req0 wins afterwards.
        rsp_ready = 1'b0;
        issue(0, WIDTH'(64'h40));
        wait_hold(10);
        tick();
        rst = 1'b1;
        issue(1, WIDTH'(64'h2));
        issue(0, WIDTH'(64'h100));
        tick();
        rst   = 1'b0;
        start = grant_log.size();
        repeat (3) tick();
        check_grant("post_reset_grant", start, 0);
        rsp_ready = 1'b1;
        wait_done(30);
        check_grant("post_reset_next", start + 1, 1);
        repeat (2) tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
